// File: rtl/bram_rd_pipe_pkg.sv
// bram_rd_pipe_pkg: sizing helpers and parameter legality shared by bram_rd_pipe and its FIFO
package bram_rd_pipe_pkg;
  localparam int MAX_RD_LAT = 4;
  function automatic int w_level(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic bit params_ok(input int rd_lat, input int depth);
    return rd_lat >= 1 && rd_lat <= MAX_RD_LAT && depth >= 2;
  endfunction
endpackage

// File: rtl/bram_rd_pipe_fifo.sv
// sync_fifo: circular-buffer FIFO with explicit occupancy count and no write-through
module sync_fifo import bram_rd_pipe_pkg::*; #(
  parameter int W_DATA = 11,
  parameter int DEPTH = 4,
  localparam int W_LEVEL = w_level(DEPTH),
  localparam int W_PTR = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [W_DATA-1:0]  din,
  output logic [W_DATA-1:0]  dout,
  output logic [W_LEVEL-1:0] level
);
  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_PTR-1:0] wr_ptr, rd_ptr;
  function automatic logic [W_PTR-1:0] nxt(input logic [W_PTR-1:0] p);
    return p == W_PTR'(DEPTH - 1) ? '0 : p + W_PTR'(1);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      level <= level + W_LEVEL'(push) - W_LEVEL'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/bram_rd_pipe.sv
// bram_rd_pipe: pipelined valid/ready read front-end for a synchronous ROM with a credit-guarded output FIFO
module bram_rd_pipe import bram_rd_pipe_pkg::*; #(
  parameter int W_DATA = 11,
  parameter int W_ADDR = 5,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int W_LEVEL = w_level(FIFO_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     addr_valid,
  output logic                     addr_ready,
  input  logic [W_ADDR-1:0]        addr_data,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic signed [W_DATA-1:0] data,
  output logic                     ena,
  output logic [W_ADDR-1:0]        addra,
  input  logic signed [W_DATA-1:0] doa,
  output logic [W_LEVEL-1:0]       level
);
  localparam int W_INF = w_level(RD_LAT);
  if (!params_ok(RD_LAT, FIFO_DEPTH)) begin : g_bad_params
    $error("bram_rd_pipe: illegal RD_LAT=%0d FIFO_DEPTH=%0d", RD_LAT, FIFO_DEPTH);
  end
  logic [RD_LAT-1:0] valid_sr;
  logic [W_INF-1:0] inflight;
  logic accept, ret;
  // Credit check uses only registered terms so addr_ready never depends on data_ready
  assign addr_ready = !rst && (int'(inflight) + int'(level) < FIFO_DEPTH);
  assign accept = addr_valid && addr_ready;
  assign ena = accept;
  assign addra = addr_data;
  assign ret = valid_sr[RD_LAT-1];
  assign data_valid = level != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
      inflight <= '0;
    end else begin
      valid_sr <= (valid_sr << 1) | RD_LAT'(accept);
      inflight <= inflight + W_INF'(accept) - W_INF'(ret);
    end
  end
  sync_fifo #(.W_DATA(W_DATA), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(ret),
    .pop(data_valid && data_ready),
    .din(doa),
    .dout(data),
    .level(level)
  );
endmodule

// File: tb/tb_bram_rd_pipe.sv
// tb_bram_rd_pipe: directed bench for bram_rd_pipe with a ROM model and in-order scoreboard
module tb_bram_rd_pipe;
  localparam int RD_LAT = 2;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic addr_valid = 1'b0;
  logic addr_ready;
  logic [4:0] addr_data = '0;
  logic data_valid;
  logic data_ready = 1'b0;
  logic signed [10:0] data;
  logic ena;
  logic [4:0] addra;
  logic signed [10:0] doa, p1, p2;
  logic [2:0] level;
  int tests = 0, fails = 0;
  int acc, pops, cyc_n, first_pop, last_pop, drops;
  logic hold = 1'b0;
  logic signed [10:0] hold_data;
  logic signed [10:0] exp_q[$];

  always #5 clk = ~clk;

  bram_rd_pipe #(.W_DATA(11), .W_ADDR(5), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_data(addr_data), .data_valid(data_valid), .data_ready(data_ready),
    .data(data), .ena(ena), .addra(addra), .doa(doa), .level(level)
  );

  function automatic logic signed [10:0] rom(input logic [4:0] a);
    return 11'(int'(a) * 7 - 38);
  endfunction

  // Two-stage ROM model matching RD_LAT=2
  always @(posedge clk) begin
    if (ena) p1 <= rom(addra);
    p2 <= p1;
  end
  assign doa = p2;

  always @(negedge clk) begin
    if (!rst && dut.ret) begin
      tests++;
      assert (level != 3'(DEPTH)) else begin
        fails++;
        $error("FAIL overflow: push with level=%0d", level);
      end
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic av, input logic [4:0] a, input logic dr);
    @(negedge clk);
    rst = r;
    addr_valid = av;
    addr_data = a;
    data_ready = dr;
    #1;
    if (hold) begin
      check("hold_valid", data_valid, 1);
      check("hold_data", data, hold_data);
    end
    if (r) exp_q.delete();
    else begin
      if (addr_valid && addr_ready) begin
        exp_q.push_back(rom(a));
        acc++;
      end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", data_valid, 0);
        else check("pop_data", data, exp_q.pop_front());
        pops++;
        if (first_pop < 0) first_pop = cyc_n;
        last_pop = cyc_n;
      end
    end
    hold = !r && data_valid && !data_ready;
    hold_data = data;
    cyc_n++;
  endtask

  task automatic phase_start();
    acc = 0;
    pops = 0;
    first_pop = -1;
    last_pop = -1;
  endtask

  initial begin
    cyc_n = 0;
    phase_start();
    // reset with a pending request: nothing may be enabled
    repeat (3) cyc(1, 1, 5, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_addr_ready", addr_ready, 0);
    check("rst_ena", ena, 0);
    check("rst_level", level, 0);

    // single read of addr 5
    cyc(0, 1, 5, 0);
    check("first_addr_ready", addr_ready, 1);
    check("single_ena", ena, 1);
    check("single_addra", addra, 5);
    cyc(0, 0, 0, 0);
    check("single_lat1", data_valid, 0);
    cyc(0, 0, 0, 0);
    check("single_lat2", data_valid, 0);
    cyc(0, 0, 0, 0);
    check("single_valid", data_valid, 1);
    check("single_data", data, -3);
    check("single_level1", level, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("single_level0", level, 0);
    check("single_empty", data_valid, 0);

    // backpressure: only DEPTH accepts while data_ready is low
    phase_start();
    for (int i = 0; i < 8; i++) cyc(0, 1, 5'(10 + i), 0);
    check("bp_accepts", acc, 4);
    check("bp_level", level, 4);
    check("bp_addr_ready", addr_ready, 0);
    check("bp_head", data, rom(5'd10));
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("bp_ready_after_pop", addr_ready, 1);
    check("bp_level_after_pop", level, 3);
    repeat (5) cyc(0, 0, 0, 1);
    check("bp_drained_q", exp_q.size(), 0);
    check("bp_drained_level", level, 0);
    check("bp_pops", pops, 4);

    // streaming 0..31 back-to-back
    phase_start();
    drops = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 5'(i), 1);
      if (!addr_ready) drops++;
    end
    repeat (6) cyc(0, 0, 0, 1);
    check("stream_drops", drops, 0);
    check("stream_accepts", acc, 32);
    check("stream_pops", pops, 32);
    check("stream_gapless", last_pop - first_pop, 31);
    check("stream_drained", exp_q.size(), 0);

    // random stalls: hold checks and scoreboard run every cycle
    phase_start();
    for (int i = 0; i < 60; i++)
      cyc(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    repeat (12) cyc(0, 0, 0, 1);
    check("rand_drained", exp_q.size(), 0);
    check("rand_balance", pops, acc);
    check("rand_empty", data_valid, 0);

    // reset mid-stream with 2 in flight and level 2
    phase_start();
    for (int i = 1; i <= 4; i++) cyc(0, 1, 5'(i), 0);
    check("mid_accepts", acc, 4);
    cyc(1, 1, 9, 0);
    check("mid_level_pre", level, 2);
    check("mid_rst_ready", addr_ready, 0);
    cyc(0, 0, 0, 0);
    check("mid_valid_post", data_valid, 0);
    check("mid_level_post", level, 0);
    check("mid_ready_post", addr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      check("mid_no_stale", data_valid, 0);
    end
    cyc(0, 1, 7, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("mid_new_valid", data_valid, 1);
    check("mid_new_data", data, 11);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("mid_final_level", level, 0);
    check("mid_final_q", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bram_rd_pipe.md
# bram_rd_pipe

Parametrised, fully pipelined read front-end for a synchronous single-port ROM/BRAM. It converts a valid/ready address stream into a valid/ready data stream. It tolerates ROM read latencies of 1–4 cycles, sustains one read per cycle, and absorbs downstream backpressure with an internal output FIFO guarded by a credit count. It is the next-generation replacement for the single-outstanding BRAM read port used in front of the classifier's coefficient and threshold ROMs.

## Interface
Parameters:
- W_DATA, 11, data width; data is passed through bit-exact as signed.
- W_ADDR, 5, ROM address width.
- RD_LAT, 1, ROM read latency in cycles (1..4): doa is valid RD_LAT cycles after ena is asserted.
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ RD_LAT+2 for full throughput and ≥ 2 for legality. A power of two is not required.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- addr_valid  in  1  address request valid.
- addr_ready  out  1  address request accepted when high together with addr_valid.
- addr_data  in  W_ADDR  ROM address.
- data_valid  out  1  read data valid.
- data_ready  in  1  downstream consumes data when high together with data_valid.
- data  out  W_DATA signed  read data, FIFO head.
- ena  out  1  ROM enable; equals addr_valid & addr_ready (combinational).
- addra  out  W_ADDR  ROM address; equals addr_data (combinational, don't-care when ena=0).
- doa  in  W_DATA signed  ROM read data.
- level  out  $clog2(FIFO_DEPTH+1)  registered FIFO occupancy, for debug and perf counters.

## Operation
- Accept = addr_valid & addr_ready. On accept, the ROM is read the same cycle through ena/addra.
- valid_sr is an RD_LAT-bit shift register. Bit 0 is set on accept. When the MSB is set, doa is written into the FIFO that cycle.
- inflight = popcount(valid_sr), kept as a registered counter. It increments on accept and decrements on ROM return; both in one cycle means no change.
- Credit rule: addr_ready = !rst & (inflight + level < FIFO_DEPTH). This uses registered terms only, so there is no combinational path from data_ready or addr_valid to addr_ready.
- The FIFO is a circular buffer with wr_ptr/rd_ptr wrapping at FIFO_DEPTH−1 → 0, and an explicit count (level).
  - Push and pop in the same cycle leaves level unchanged.
  - Push into an empty FIFO becomes visible the next cycle. There is no write-through bypass.
- data_valid = (level ≠ 0). data = mem[rd_ptr]. Pop = data_valid & data_ready.
- Ordering: data is returned strictly in address-accept order.
- The credit rule guarantees no overflow: a ROM return always finds a free slot. A bench assertion flags any push while level == FIFO_DEPTH.
- Reset (rst high, any cycle, including mid-stream):
  - valid_sr, inflight, level, wr_ptr and rd_ptr are cleared.
  - data_valid=0, addr_ready=0, ena=0, level=0. The addra and data values are don't-care.
  - In-flight ROM returns are discarded.
  - addr_ready may rise in the first cycle after rst deasserts.

## Timing
- Latency: accept in cycle t gives ROM data in cycle t+RD_LAT, and data_valid in cycle t+RD_LAT+1 if the FIFO was empty and not being read.
- Throughput: 1 accept per cycle sustained while data_ready=1 and FIFO_DEPTH ≥ RD_LAT+2.
- Backpressure: with data_ready held low, at most FIFO_DEPTH addresses are accepted. addr_ready then stays low until a pop.
- After a pop, addr_ready rises the next cycle because level is registered.
- data and data_valid hold stable while data_valid=1 and data_ready=0. This is AXI-stream style and required.
- A ROM read fires only on accept, so the ROM is never enabled speculatively.

## Structure
- The shared package gets localparam helpers: the W_LEVEL calculation ($clog2(FIFO_DEPTH+1)) and a parameter-legality check function (RD_LAT in 1..4, FIFO_DEPTH ≥ 2). These are used by an elaboration-time assertion.
- One sub-module, sync_fifo (W_DATA, DEPTH, push/pop/level). The credit logic and shift register stay in bram_rd_pipe.
- bram_rd_pipe replaces the existing rd-port + dreg pair in the threshold and coefficient ROM wrappers.

## Test plan
- Single read, RD_LAT=1, ROM[5]=−3: accept addr 5 at cycle 10 → data_valid at cycle 12 with data=−3; level goes 1 then 0 after the pop.
- Streaming, RD_LAT=2, FIFO_DEPTH=4, addresses 0..31 back-to-back with data_ready=1 → addr_ready never drops; 32 results in order; one output per cycle once the stream fills.
- Backpressure, RD_LAT=3, FIFO_DEPTH=5, data_ready=0 with valid addresses pending → exactly 5 accepts, then addr_ready=0 and level=5. Raising data_ready for 1 cycle → one pop, and addr_ready=1 the next cycle.
- Stall stability: data_valid=1 with data_ready toggling randomly → data holds while not popped; no loss and no duplication against a reference queue.
- Reset mid-operation with 3 in flight and level=2: assert rst for 1 cycle → data_valid=0 and level=0 next cycle. Stale returns never appear; a new read of addr 7 returns ROM[7] only.
- Parameter sweep with random valid/ready, RD_LAT ∈ {1..4} and FIFO_DEPTH ∈ {2, RD_LAT+2, 8} → scoreboard in-order match. The no-overflow assertion never fires.
